halut_decoder_ctrl: RTL and testbench

Sequencer for one `halut_decoder` datapath. It first loads the C×K LUT from a valid/ready word stream, then streams encoded prototype indices through the decoder, one per cycle, one row of C indices at a time. It captures each finished FP32 row sum into a one-entry output buffer with a valid/ready handshake. It sits between the accelerator's DMA/encoder front end and a single decoder instance.

---
 rtl/halut_decoder_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_halut_decoder_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/halut_decoder_ctrl.sv
// rtl/halut_decoder_ctrl.sv - Sequencer that loads the HALUT LUT and streams encoded rows through one decoder
//
// Purpose: LOAD writes C*K LUT words to the decoder in address order. RUN then feeds one
// prototype index per cycle, C indices per row. Each finished row sum is captured into a
// one-entry valid/ready output buffer. FLUSH waits for the last result to be consumed and
// then pulses done_o.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   start_i, rows_i, load_lut_i      job request (sampled in IDLE)
//   lut_valid_i/lut_data_i/lut_ready_o   LUT word stream
//   enc_valid_i/enc_k_i/enc_ready_o      encoded index stream
//   waddr_o, wdata_o, we_o           decoder LUT write port
//   c_addr_o, k_addr_o, decoder_o    decoder lookup port
//   dec_result_i                     decoder row result
//   res_valid_o/res_data_o/res_ready_i   row result buffer
//   busy_o, done_o                   job status
//
// Optional feature macro: HALUT_CTRL_PERF_CNT_EN adds perf_cycles_o and perf_stalls_o.

module halut_decoder_ctrl #(
    parameter int K              = 16,
    parameter int C              = 32,
    parameter int DataTypeWidth  = 16,
    parameter int RowCntWidth    = 16,
    parameter int TotalAddrWidth = $clog2(C * K),
    parameter int CAddrWidth     = $clog2(C),
    parameter int TreeDepth      = $clog2(K)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [RowCntWidth-1:0]    rows_i,
    input  logic                      load_lut_i,
    input  logic                      lut_valid_i,
    input  logic [DataTypeWidth-1:0]  lut_data_i,
    output logic                      lut_ready_o,
    input  logic                      enc_valid_i,
    input  logic [TreeDepth-1:0]      enc_k_i,
    output logic                      enc_ready_o,
    output logic [TotalAddrWidth-1:0] waddr_o,
    output logic [DataTypeWidth-1:0]  wdata_o,
    output logic                      we_o,
    output logic [CAddrWidth-1:0]     c_addr_o,
    output logic [TreeDepth-1:0]      k_addr_o,
    output logic                      decoder_o,
    input  logic [31:0]               dec_result_i,
    output logic                      res_valid_o,
    output logic [31:0]               res_data_o,
    input  logic                      res_ready_i,
    output logic                      busy_o,
    output logic                      done_o
`ifdef HALUT_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]               perf_cycles_o,
    output logic [31:0]               perf_stalls_o
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_e;

    state_e                    state_q, state_d;
    logic [TotalAddrWidth-1:0] waddr_q, waddr_d;
    logic [CAddrWidth-1:0]     c_q, c_d;
    logic [RowCntWidth-1:0]    row_q, row_d;
    logic [RowCntWidth-1:0]    rows_q, rows_d;
    logic                      cap_q, cap_d;
    logic                      done_q, done_d;
    logic                      res_valid_q, res_valid_d;
    logic [31:0]               res_data_q, res_data_d;

    logic last_word;
    logic last_c;
    logic stall;

    assign last_word = (waddr_q == TotalAddrWidth'(C * K - 1));
    assign last_c    = (c_q == CAddrWidth'(C - 1));
    // Holding the row-end index keeps the next row from finishing while the buffer is still occupied.
    assign stall     = last_c && res_valid_q && !res_ready_i;

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        c_d         = c_q;
        row_d       = row_q;
        rows_d      = rows_q;
        cap_d       = 1'b0;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        lut_ready_o = 1'b0;
        we_o        = 1'b0;
        waddr_o     = '0;
        wdata_o     = '0;
        enc_ready_o = 1'b0;
        decoder_o   = 1'b0;
        c_addr_o    = '0;
        k_addr_o    = '0;

        // Capture wins over consume, so a same-cycle consume/capture keeps valid set.
        if (res_valid_q && res_ready_i) begin
            res_valid_d = 1'b0;
        end
        if (cap_q) begin
            res_valid_d = 1'b1;
            res_data_d  = dec_result_i;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (rows_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rows_d  = rows_i;
                        row_d   = '0;
                        c_d     = '0;
                        waddr_d = '0;
                        state_d = load_lut_i ? LOAD : RUN;
                    end
                end
            end
            LOAD: begin
                lut_ready_o = 1'b1;
                if (lut_valid_i) begin
                    we_o    = 1'b1;
                    waddr_o = waddr_q;
                    wdata_o = lut_data_i;
                    if (last_word) begin
                        waddr_d = '0;
                        state_d = RUN;
                    end else begin
                        waddr_d = waddr_q + TotalAddrWidth'(1);
                    end
                end
            end
            RUN: begin
                enc_ready_o = !stall;
                if (enc_valid_i && !stall) begin
                    decoder_o = 1'b1;
                    c_addr_o  = c_q;
                    k_addr_o  = enc_k_i;
                    if (last_c) begin
                        c_d   = '0;
                        // Decoder registers the row sum next cycle; capture one cycle after that.
                        cap_d = 1'b1;
                        row_d = row_q + RowCntWidth'(1);
                        if (row_q == rows_q - RowCntWidth'(1)) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        c_d = c_q + CAddrWidth'(1);
                    end
                end
            end
            FLUSH: begin
                if (!cap_q && (!res_valid_q || res_ready_i)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            c_q         <= '0;
            row_q       <= '0;
            rows_q      <= '0;
            cap_q       <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            c_q         <= c_d;
            row_q       <= row_d;
            rows_q      <= rows_d;
            cap_q       <= cap_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

`ifdef HALUT_CTRL_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (state_q == IDLE && start_i) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (busy_o && perf_cycles_q != '1) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            if (state_q == RUN && enc_valid_i && !enc_ready_o && perf_stalls_q != '1) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stalls_o = perf_stalls_q;
`endif

endmodule

// File: tb/tb_halut_decoder_ctrl.sv
// tb/tb_halut_decoder_ctrl.sv - Self-checking bench for halut_decoder_ctrl with a behavioural decoder
module tb_halut_decoder_ctrl;
    localparam int K   = 16;
    localparam int C   = 32;
    localparam int DW  = 16;
    localparam int RW  = 16;
    localparam int TAW = $clog2(C * K);
    localparam int CAW = $clog2(C);
    localparam int TD  = $clog2(K);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i = 1'b1, start_i = 1'b0, load_lut_i = 1'b0;
    logic [RW-1:0]  rows_i = '0;
    logic           lut_valid_i = 1'b0, enc_valid_i = 1'b0, res_ready_i = 1'b0;
    logic [DW-1:0]  lut_data_i = '0;
    logic [TD-1:0]  enc_k_i = '0;
    logic           lut_ready_o, enc_ready_o, we_o, decoder_o, res_valid_o, busy_o, done_o;
    logic [TAW-1:0] waddr_o;
    logic [DW-1:0]  wdata_o;
    logic [CAW-1:0] c_addr_o;
    logic [TD-1:0]  k_addr_o;
    logic [31:0]    dec_result_i, res_data_o;

    halut_decoder_ctrl #(.K(K), .C(C), .DataTypeWidth(DW), .RowCntWidth(RW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i), .load_lut_i(load_lut_i),
        .lut_valid_i(lut_valid_i), .lut_data_i(lut_data_i), .lut_ready_o(lut_ready_o),
        .enc_valid_i(enc_valid_i), .enc_k_i(enc_k_i), .enc_ready_o(enc_ready_o),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
        .c_addr_o(c_addr_o), .k_addr_o(k_addr_o), .decoder_o(decoder_o),
        .dec_result_i(dec_result_i), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
        .res_ready_i(res_ready_i), .busy_o(busy_o), .done_o(done_o)
    );

    // Behavioural decoder: LUT memory, running sum restarted at c=0, result presented for one cycle only.
    logic [DW-1:0] dec_lut [C*K];
    logic [31:0]   dec_acc = '0, dec_res = '0;
    logic          dec_res_v = 1'b0;
    logic [31:0]   dec_sum;
    assign dec_sum      = ((c_addr_o == '0) ? 32'd0 : dec_acc) + 32'(dec_lut[{c_addr_o, k_addr_o}]);
    assign dec_result_i = dec_res_v ? dec_res : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        dec_res_v <= 1'b0;
        if (we_o) dec_lut[waddr_o] <= wdata_o;
        if (decoder_o) begin
            dec_acc <= dec_sum;
            if (c_addr_o == CAW'(C - 1)) begin
                dec_res   <= dec_sum;
                dec_res_v <= 1'b1;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference LUT contents as accepted from the stream, indexed by the bench's own word count.
    logic [DW-1:0] lut_ref [C*K];

    // Observations of the last job.
    int n_we, n_busy, n_done, done_cyc, last_cons, idle_bad, stall_cyc, release_c, hold_changes;
    int last_we_cyc, first_rdy, busy_at_done, timed_out;
    int q_waddr[$], q_caddr[$], q_hs31[$], q_vrise[$];
    logic [DW-1:0] q_wdata[$], q_wsent[$];
    logic [31:0]   q_res[$], q_exp[$];

    task automatic run_job(input int rows, input bit load, input int vpct, input int rpct,
                           input int hold, input int abort_row, input int abort_c);
        int words = 0, sent_c = 0, sent_rows = 0;
        bit prev_v = 1'b0, stalled = 1'b0, have_held = 1'b0, run_phase;
        logic [31:0] acc = '0, held = '0;
        n_we = 0; n_busy = 0; n_done = 0; done_cyc = -1; last_cons = -1; idle_bad = 0;
        stall_cyc = 0; release_c = -1; hold_changes = 0; last_we_cyc = -1; first_rdy = -1;
        busy_at_done = -1; timed_out = 1;
        q_waddr.delete(); q_caddr.delete(); q_hs31.delete(); q_vrise.delete();
        q_wdata.delete(); q_wsent.delete(); q_res.delete(); q_exp.delete();
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if (abort_row >= 0 && sent_rows == abort_row && sent_c == abort_c) begin
                rst_i = 1'b1; start_i = 1'b0; lut_valid_i = 1'b0; enc_valid_i = 1'b0; res_ready_i = 1'b0;
                timed_out = 0;
                return;
            end
            start_i     = (cyc == 0);
            rows_i      = (cyc == 0) ? RW'(rows) : '0;
            load_lut_i  = (cyc == 0) ? load : 1'b0;
            lut_valid_i = ($urandom_range(99) < vpct);
            lut_data_i  = DW'($urandom);
            enc_valid_i = (sent_rows < rows) && ($urandom_range(99) < vpct);
            enc_k_i     = TD'($urandom);
            res_ready_i = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rpct);
            #1;
            run_phase = (cyc > 0) && (!load || words == C * K) && (sent_rows < rows);
            if (busy_o) n_busy++;
            if (we_o) begin
                n_we++; last_we_cyc = cyc;
                q_waddr.push_back(int'(waddr_o)); q_wdata.push_back(wdata_o); q_wsent.push_back(lut_data_i);
            end
            if (lut_ready_o && lut_valid_i) begin
                lut_ref[words] = lut_data_i;
                words++;
            end
            if (decoder_o) q_caddr.push_back(int'(c_addr_o));
            else if (c_addr_o != '0 || k_addr_o != '0) idle_bad++;
            if (enc_ready_o && first_rdy < 0) first_rdy = cyc;
            if (run_phase && enc_valid_i && !enc_ready_o) begin
                stall_cyc++; stalled = 1'b1;
            end
            if (enc_valid_i && enc_ready_o) begin
                if (stalled && release_c < 0) release_c = int'(c_addr_o);
                acc += 32'(lut_ref[sent_c * K + int'(enc_k_i)]);
                if (sent_c == C - 1) begin
                    q_exp.push_back(acc); acc = '0; sent_c = 0; sent_rows++; q_hs31.push_back(cyc);
                end else begin
                    sent_c++;
                end
            end
            if (res_valid_o && !prev_v) q_vrise.push_back(cyc);
            if (cyc < hold && res_valid_o) begin
                if (have_held && res_data_o != held) hold_changes++;
                held = res_data_o; have_held = 1'b1;
            end
            if (res_valid_o && res_ready_i) begin
                q_res.push_back(res_data_o); last_cons = cyc;
            end
            prev_v = res_valid_o;
            if (done_o) begin
                n_done++; done_cyc = cyc; busy_at_done = int'(busy_o);
            end
            if (n_done > 0 && cyc >= done_cyc + 3) begin
                timed_out = 0;
                break;
            end
        end
        start_i = 1'b0; lut_valid_i = 1'b0; enc_valid_i = 1'b0; res_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; lut_valid_i = 1'b1; enc_valid_i = 1'b1; res_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
        checks++; if (res_valid_o !== 1'b0 || res_data_o !== 32'd0) begin errors++;
            $display("FAIL reset_result: got valid=%b data=%h expected 0/0", res_valid_o, res_data_o); end
        checks++; if ({lut_ready_o, enc_ready_o, we_o, decoder_o} !== 4'b0) begin errors++;
            $display("FAIL reset_handshakes: got %b expected 0000", {lut_ready_o, enc_ready_o, we_o, decoder_o}); end
        checks++; if (waddr_o !== '0 || wdata_o !== '0 || c_addr_o !== '0 || k_addr_o !== '0) begin errors++;
            $display("FAIL reset_addr: got waddr=%0d wdata=%0d c=%0d k=%0d expected 0", waddr_o, wdata_o, c_addr_o, k_addr_o); end
        lut_valid_i = 1'b0; enc_valid_i = 1'b0; res_ready_i = 1'b0;
        rst_i = 1'b0;
    endtask

    task automatic test_load;
        int bad_a = -1, bad_d = -1;
        run_job(1, 1'b1, 60, 100, 0, -1, -1);
        checks++; if (timed_out != 0) begin errors++; $display("FAIL load_timeout: got no done expected done"); end
        checks++; if (n_we != C * K) begin errors++; $display("FAIL load_we_count: got %0d expected %0d", n_we, C * K); end
        for (int i = 0; i < q_waddr.size(); i++) begin
            if (q_waddr[i] != i && bad_a < 0) bad_a = i;
            if (q_wdata[i] !== q_wsent[i] && bad_d < 0) bad_d = i;
        end
        checks++; if (bad_a != -1) begin errors++;
            $display("FAIL load_waddr_order: got waddr %0d at pulse %0d expected %0d", q_waddr[bad_a], bad_a, bad_a); end
        checks++; if (bad_d != -1) begin errors++;
            $display("FAIL load_wdata: got %h at pulse %0d expected %h", q_wdata[bad_d], bad_d, q_wsent[bad_d]); end
        checks++; if (first_rdy != last_we_cyc + 1) begin errors++;
            $display("FAIL load_to_run: got enc_ready at cycle %0d expected %0d", first_rdy, last_we_cyc + 1); end
        checks++; if (q_res.size() != 1 || q_exp.size() != 1) begin errors++;
            $display("FAIL load_row_count: got %0d results expected %0d", q_res.size(), q_exp.size()); end
        else begin
            checks++; if (q_res[0] !== q_exp[0]) begin errors++;
                $display("FAIL load_row_sum: got %h expected %h", q_res[0], q_exp[0]); end
        end
    endtask

    task automatic test_rows3;
        int bad_c = -1;
        run_job(3, 1'b0, 100, 100, 0, -1, -1);
        checks++; if (q_caddr.size() != 3 * C) begin errors++;
            $display("FAIL rows3_decoder_count: got %0d expected %0d", q_caddr.size(), 3 * C); end
        for (int i = 0; i < q_caddr.size(); i++) if (q_caddr[i] != i % C && bad_c < 0) bad_c = i;
        checks++; if (bad_c != -1) begin errors++;
            $display("FAIL rows3_caddr_seq: got %0d at step %0d expected %0d", q_caddr[bad_c], bad_c, bad_c % C); end
        checks++; if (q_res.size() != 3) begin errors++; $display("FAIL rows3_result_count: got %0d expected 3", q_res.size()); end
        for (int i = 0; i < q_res.size() && i < q_exp.size(); i++) begin
            checks++; if (q_res[i] !== q_exp[i]) begin errors++;
                $display("FAIL rows3_sum_%0d: got %h expected %h", i, q_res[i], q_exp[i]); end
        end
        for (int i = 0; i < q_hs31.size(); i++) begin
            checks++; if (i >= q_vrise.size() || q_vrise[i] != q_hs31[i] + 2) begin errors++;
                $display("FAIL rows3_latency_%0d: got valid at %0d expected %0d", i,
                         (i < q_vrise.size()) ? q_vrise[i] : -1, q_hs31[i] + 2); end
        end
        checks++; if (n_done != 1 || done_cyc != last_cons + 1) begin errors++;
            $display("FAIL rows3_done: got %0d pulses at cycle %0d expected 1 at %0d", n_done, done_cyc, last_cons + 1); end
        checks++; if (busy_at_done != 0) begin errors++; $display("FAIL rows3_busy_at_done: got %0d expected 0", busy_at_done); end
    endtask

    task automatic test_stall;
        run_job(3, 1'b0, 100, 100, 100, -1, -1);
        checks++; if (stall_cyc < 20) begin errors++; $display("FAIL stall_seen: got %0d stall cycles expected at least 20", stall_cyc); end
        checks++; if (release_c != C - 1) begin errors++; $display("FAIL stall_c_counter: got %0d expected %0d", release_c, C - 1); end
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL stall_idle_addr: got %0d nonzero idle cycles expected 0", idle_bad); end
        checks++; if (hold_changes != 0) begin errors++; $display("FAIL stall_result_stable: got %0d changes expected 0", hold_changes); end
        checks++; if (q_res.size() != 3) begin errors++; $display("FAIL stall_result_count: got %0d expected 3", q_res.size()); end
        for (int i = 0; i < q_res.size() && i < q_exp.size(); i++) begin
            checks++; if (q_res[i] !== q_exp[i]) begin errors++;
                $display("FAIL stall_sum_%0d: got %h expected %h", i, q_res[i], q_exp[i]); end
        end
    endtask

    task automatic test_back_to_back;
        run_job(6, 1'b0, 75, 45, 0, -1, -1);
        checks++; if (q_res.size() != 6) begin errors++; $display("FAIL b2b_result_count: got %0d expected 6", q_res.size()); end
        for (int i = 0; i < q_res.size() && i < q_exp.size(); i++) begin
            checks++; if (q_res[i] !== q_exp[i]) begin errors++;
                $display("FAIL b2b_sum_%0d: got %h expected %h", i, q_res[i], q_exp[i]); end
        end
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL b2b_idle_addr: got %0d expected 0", idle_bad); end
        checks++; if (n_done != 1 || done_cyc != last_cons + 1) begin errors++;
            $display("FAIL b2b_done: got %0d pulses at cycle %0d expected 1 at %0d", n_done, done_cyc, last_cons + 1); end
    endtask

    task automatic test_midjob_reset;
        run_job(3, 1'b0, 100, 100, 0, 1, 17);
        @(negedge clk);
        #1;
        checks++; if ({busy_o, done_o, res_valid_o, enc_ready_o, decoder_o, lut_ready_o, we_o} !== 7'b0) begin errors++;
            $display("FAIL midreset_flags: got %b expected 0000000",
                     {busy_o, done_o, res_valid_o, enc_ready_o, decoder_o, lut_ready_o, we_o}); end
        checks++; if (res_data_o !== 32'd0 || c_addr_o !== '0) begin errors++;
            $display("FAIL midreset_data: got data=%h c=%0d expected 0/0", res_data_o, c_addr_o); end
        rst_i = 1'b0;
        run_job(2, 1'b0, 85, 70, 0, -1, -1);
        checks++; if (q_res.size() != 2) begin errors++; $display("FAIL midreset_result_count: got %0d expected 2", q_res.size()); end
        for (int i = 0; i < q_res.size() && i < q_exp.size(); i++) begin
            checks++; if (q_res[i] !== q_exp[i]) begin errors++;
                $display("FAIL midreset_sum_%0d: got %h expected %h", i, q_res[i], q_exp[i]); end
        end
    endtask

    task automatic test_zero_rows;
        run_job(0, 1'b1, 100, 100, 0, -1, -1);
        checks++; if (n_done != 1 || done_cyc != 1) begin errors++;
            $display("FAIL zero_done: got %0d pulses at cycle %0d expected 1 at 1", n_done, done_cyc); end
        checks++; if (n_busy != 0) begin errors++; $display("FAIL zero_busy: got %0d busy cycles expected 0", n_busy); end
        checks++; if (q_caddr.size() != 0 || n_we != 0) begin errors++;
            $display("FAIL zero_activity: got %0d lookups %0d writes expected 0", q_caddr.size(), n_we); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_rows3();
        test_stall();
        test_back_to_back();
        test_midjob_reset();
        test_zero_rows();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
